// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I opcode constants, control-word types and small decode helpers
// used by the pipelined control unit and its main decoder.
package rv_ctrl_pkg;

  localparam int OP_W = 7;
  localparam int F3_W = 3;
  localparam int F7_W = 7;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  localparam logic [F7_W-1:0] F7_BASE = 7'h00;
  localparam logic [F7_W-1:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic             alu_a_sel;
    logic             alu_src;
    alu_op_e          alu_op;
    logic             branch;
    logic             jump;
    logic             jalr;
    logic             mem_wr;
    logic             mem_rd;
    logic [F3_W-1:0]  funct3;
    logic             reg_wr;
    wb_sel_e          wb_sel;
  } ctrl_t;

  // The all-zero word doubles as a NOP: no writes, no redirect, ADD on the ALU.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // funct7[5] turns ADD into SUB only where sub_allowed (R-type); shifts honour it in R and I forms.
  function automatic alu_op_e alu_op_from_funct(input logic [F3_W-1:0] funct3,
                                                input logic            alt,
                                                input logic            sub_allowed);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (alt && sub_allowed) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic branch_taken(input logic [F3_W-1:0] funct3,
                                        input logic            zero,
                                        input logic            lt,
                                        input logic            ltu);
    logic taken;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/rv_main_decoder.sv
// Combinational RV32I main decoder: opcode/funct3/funct7 to control word,
// immediate format select and an illegal-encoding flag.
module rv_main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op_code,
  input  logic [F3_W-1:0] funct3,
  input  logic [F7_W-1:0] funct7,
  output ctrl_t           ctrl,
  output imm_sel_e        imm_sel,
  output logic            illegal
);

  always_comb begin
    ctrl        = CTRL_BUBBLE;
    imm_sel     = IMM_I;
    illegal     = 1'b0;
    ctrl.funct3 = funct3;

    case (op_code)
      OP_R: begin
        ctrl.reg_wr = 1'b1;
        ctrl.wb_sel = WB_ALU;
        ctrl.alu_op = alu_op_from_funct(funct3, funct7[5], 1'b1);
        illegal     = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end

      OP_I: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.wb_sel  = WB_ALU;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = alu_op_from_funct(funct3, funct7[5], 1'b0);
      end

      OP_LOAD: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.wb_sel  = WB_MEM;
        ctrl.alu_src = 1'b1;
        ctrl.mem_rd  = 1'b1;
        illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end

      OP_STORE: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_wr  = 1'b1;
        imm_sel      = IMM_S;
        illegal      = (funct3 > 3'b010);
      end

      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
        imm_sel     = IMM_B;
        illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
      end

      OP_JAL: begin
        ctrl.reg_wr    = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_a_sel = 1'b1;
        ctrl.jump      = 1'b1;
        imm_sel        = IMM_J;
      end

      OP_JALR: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.wb_sel  = WB_PC4;
        ctrl.alu_src = 1'b1;
        ctrl.jump    = 1'b1;
        ctrl.jalr    = 1'b1;
        illegal      = (funct3 != 3'b000);
      end

      OP_LUI: begin
        ctrl.reg_wr = 1'b1;
        ctrl.wb_sel = WB_IMM;
        imm_sel     = IMM_U;
      end

      OP_AUIPC: begin
        ctrl.reg_wr    = 1'b1;
        ctrl.wb_sel    = WB_ALU;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_a_sel = 1'b1;
        imm_sel        = IMM_U;
      end

      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I control unit: decodes in ID and carries the control word through ID/EX, EX/MEM and MEM/WB.
// Branches and jumps resolve in EX; bubbles replace stalled, flushed, squashed or illegal instructions.
module pipelined_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OP_CODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH  = 3,
  parameter int FUNCT7_WIDTH  = 7,
  parameter int ALU_OP_WIDTH  = 4,
  parameter bit TRAP_ILLEGAL  = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_instr_valid,
  input  logic [OP_CODE_WIDTH-1:0] i_op_code,
  input  logic [FUNCT3_WIDTH-1:0]  i_funct3,
  input  logic [FUNCT7_WIDTH-1:0]  i_funct7,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic                     i_alu_zero,
  input  logic                     i_alu_lt,
  input  logic                     i_alu_ltu,
  output logic [2:0]               o_imm_sel,
  output logic                     o_ex_alu_a_sel,
  output logic                     o_ex_alu_src_sel,
  output logic [ALU_OP_WIDTH-1:0]  o_ex_alu_op,
  output logic                     o_ex_pc_src,
  output logic                     o_ex_jalr,
  output logic                     o_mem_wr_en,
  output logic                     o_mem_rd_en,
  output logic [FUNCT3_WIDTH-1:0]  o_mem_funct3,
  output logic                     o_wb_reg_wr_en,
  output logic [1:0]               o_wb_result_sel,
  output logic                     o_illegal_instr
);

  // No datapath storage lives here; the width is carried only for the integrating datapath.
  localparam int unused_data_width = DATA_WIDTH;

  ctrl_t    id_ctrl;
  imm_sel_e id_imm_sel;
  logic     id_illegal;
  logic     id_illegal_seen;
  logic     id_bubble;
  logic     illegal_d;

  ctrl_t    id_ex_q;
  ctrl_t    ex_mem_q;
  ctrl_t    mem_wb_q;
  logic     illegal_q;

  logic     ex_taken;
  logic     unused_mem_wb;

  rv_main_decoder u_main_decoder (
    .op_code (i_op_code),
    .funct3  (i_funct3),
    .funct7  (i_funct7),
    .ctrl    (id_ctrl),
    .imm_sel (id_imm_sel),
    .illegal (id_illegal)
  );

  assign ex_taken    = branch_taken(id_ex_q.funct3, i_alu_zero, i_alu_lt, i_alu_ltu);
  assign o_ex_pc_src = id_ex_q.jump || (id_ex_q.branch && ex_taken);

  // Every bubble cause is treated alike, so coincident causes still yield a single bubble.
  assign id_illegal_seen = i_instr_valid && id_illegal;
  assign id_bubble       = i_stall || i_flush || o_ex_pc_src || !i_instr_valid || id_illegal_seen;
  assign illegal_d       = TRAP_ILLEGAL && id_illegal_seen && !i_flush && !o_ex_pc_src;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      id_ex_q   <= CTRL_BUBBLE;
      ex_mem_q  <= CTRL_BUBBLE;
      mem_wb_q  <= CTRL_BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      id_ex_q   <= id_bubble ? CTRL_BUBBLE : id_ctrl;
      ex_mem_q  <= id_ex_q;
      mem_wb_q  <= ex_mem_q;
      illegal_q <= illegal_d;
    end
  end

  // WB only consumes the register-write fields of its word.
  assign unused_mem_wb = ^mem_wb_q;

  assign o_imm_sel        = id_imm_sel;
  assign o_ex_alu_a_sel   = id_ex_q.alu_a_sel;
  assign o_ex_alu_src_sel = id_ex_q.alu_src;
  assign o_ex_alu_op      = id_ex_q.alu_op;
  assign o_ex_jalr        = id_ex_q.jalr;
  assign o_mem_wr_en      = ex_mem_q.mem_wr;
  assign o_mem_rd_en      = ex_mem_q.mem_rd;
  assign o_mem_funct3     = ex_mem_q.funct3;
  assign o_wb_reg_wr_en   = mem_wb_q.reg_wr;
  assign o_wb_result_sel  = mem_wb_q.wb_sel;
  assign o_illegal_instr  = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: expected EX words are queued when an
// instruction is driven into ID and then followed through the MEM and WB slots.
module tb_pipelined_control_unit;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_BAD    = 7'h7F;

  typedef struct packed {
    logic       live;
    logic       a_sel;
    logic       src;
    logic [3:0] alu;
    logic       jalr;
    logic       branch;
    logic       jump;
    logic       mem_wr;
    logic       mem_rd;
    logic [2:0] f3;
    logic       reg_wr;
    logic [1:0] wb;
    logic       dc_alu;
    logic       dc_src;
    logic       dc_wb;
    logic       ill_pulse;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       stall, flush, alu_zero, alu_lt, alu_ltu;
  logic [2:0] imm_sel;
  logic       ex_alu_a_sel, ex_alu_src_sel, ex_pc_src, ex_jalr;
  logic [3:0] ex_alu_op;
  logic       mem_wr_en, mem_rd_en;
  logic [2:0] mem_funct3;
  logic       wb_reg_wr_en;
  logic [1:0] wb_result_sel;
  logic       illegal_instr;

  exp_t exp_q[$];
  exp_t ex_cur, mem_w, wb_w;
  int   num_checks = 0;
  int   num_errors = 0;
  int   illegal_pulses = 0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.TRAP_ILLEGAL(1'b1)) dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_instr_valid    (instr_valid),
    .i_op_code        (op_code),
    .i_funct3         (funct3),
    .i_funct7         (funct7),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_alu_zero       (alu_zero),
    .i_alu_lt         (alu_lt),
    .i_alu_ltu        (alu_ltu),
    .o_imm_sel        (imm_sel),
    .o_ex_alu_a_sel   (ex_alu_a_sel),
    .o_ex_alu_src_sel (ex_alu_src_sel),
    .o_ex_alu_op      (ex_alu_op),
    .o_ex_pc_src      (ex_pc_src),
    .o_ex_jalr        (ex_jalr),
    .o_mem_wr_en      (mem_wr_en),
    .o_mem_rd_en      (mem_rd_en),
    .o_mem_funct3     (mem_funct3),
    .o_wb_reg_wr_en   (wb_reg_wr_en),
    .o_wb_result_sel  (wb_result_sel),
    .o_illegal_instr  (illegal_instr)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
    num_checks++;
    if (got !== want) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] aluModel(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'd0:    return (is_r && f7b5) ? 4'd1 : 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd3;
      3'd3:    return 4'd4;
      3'd4:    return 4'd5;
      3'd5:    return f7b5 ? 4'd7 : 4'd6;
      3'd6:    return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic takenModel(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    case (f3)
      3'd0:    return z;
      3'd1:    return ~z;
      3'd4:    return l;
      3'd5:    return ~l;
      3'd6:    return lu;
      3'd7:    return ~lu;
      default: return 1'b0;
    endcase
  endfunction

  // Expected control word straight from the decode table; '-' entries are marked don't-care.
  function automatic exp_t modelDecode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                       output logic ill, output logic [2:0] imm, output logic imm_dc);
    exp_t e;
    e = '0; e.live = 1'b1; e.f3 = f3;
    ill = 1'b0; imm = 3'b000; imm_dc = 1'b0;
    case (op)
      OP_R:      begin e.reg_wr = 1; e.wb = 2'b01; e.alu = aluModel(f3, f7[5], 1'b1); imm_dc = 1;
                       ill = !(f7 == 7'h00 || f7 == 7'h20); end
      OP_I:      begin e.reg_wr = 1; e.wb = 2'b01; e.src = 1; e.alu = aluModel(f3, f7[5], 1'b0); end
      OP_LOAD:   begin e.reg_wr = 1; e.wb = 2'b00; e.src = 1; e.mem_rd = 1;
                       ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
      OP_STORE:  begin e.src = 1; e.mem_wr = 1; e.dc_wb = 1; imm = 3'b001; ill = (f3 > 3'd2); end
      OP_BRANCH: begin e.branch = 1; e.alu = 4'd1; e.dc_wb = 1; imm = 3'b010;
                       ill = (f3 == 3'd2 || f3 == 3'd3); end
      OP_JAL:    begin e.reg_wr = 1; e.wb = 2'b10; e.a_sel = 1; e.jump = 1; e.dc_src = 1; imm = 3'b011; end
      OP_JALR:   begin e.reg_wr = 1; e.wb = 2'b10; e.src = 1; e.jump = 1; e.jalr = 1; ill = (f3 != 3'd0); end
      OP_LUI:    begin e.reg_wr = 1; e.wb = 2'b11; e.dc_src = 1; e.dc_alu = 1; imm = 3'b100; end
      OP_AUIPC:  begin e.reg_wr = 1; e.wb = 2'b01; e.src = 1; e.a_sel = 1; imm = 3'b100; end
      default:   begin ill = 1'b1; imm_dc = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic checkStages();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 16'd1, 16'd0);
      return;
    end
    e = exp_q.pop_front();
    wb_w = mem_w; mem_w = ex_cur; ex_cur = e;
    checkOutput("ex_a_sel_jalr", 16'({ex_alu_a_sel, ex_jalr}), 16'({e.a_sel, e.jalr}));
    if (!e.dc_alu) checkOutput("ex_alu_op", 16'(ex_alu_op), 16'(e.alu));
    if (!e.dc_src) checkOutput("ex_alu_src", 16'(ex_alu_src_sel), 16'(e.src));
    checkOutput("illegal_instr", 16'(illegal_instr), 16'(e.ill_pulse));
    checkOutput("mem_wr_rd", 16'({mem_wr_en, mem_rd_en}), 16'({mem_w.mem_wr, mem_w.mem_rd}));
    if (!mem_w.live || mem_w.mem_wr || mem_w.mem_rd)
      checkOutput("mem_funct3", 16'(mem_funct3), 16'(mem_w.f3));
    checkOutput("wb_reg_wr", 16'(wb_reg_wr_en), 16'(wb_w.reg_wr));
    if (!wb_w.dc_wb) checkOutput("wb_result_sel", 16'(wb_result_sel), 16'(wb_w.wb));
    if (illegal_instr) illegal_pulses++;
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic st, input logic fl, input logic z, input logic l, input logic lu);
    exp_t dec, nxt;
    logic ill, imm_dc, exp_pc;
    logic [2:0] imm;
    @(negedge clk);
    instr_valid = v; op_code = op; funct3 = f3; funct7 = f7;
    stall = st; flush = fl; alu_zero = z; alu_lt = l; alu_ltu = lu;
    #1;
    exp_pc = ex_cur.jump | (ex_cur.branch & takenModel(ex_cur.f3, z, l, lu));
    checkOutput("ex_pc_src", 16'(ex_pc_src), 16'(exp_pc));
    dec = modelDecode(op, f3, f7, ill, imm, imm_dc);
    if (v && !ill && !imm_dc) checkOutput("imm_sel", 16'(imm_sel), 16'(imm));
    if (st || fl || exp_pc || !v || ill) nxt = '0;
    else nxt = dec;
    nxt.ill_pulse = v & ill & ~fl & ~exp_pc;
    exp_q.push_back(nxt);
    @(posedge clk); #1;
    checkStages();
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ex"}, 16'({ex_alu_a_sel, ex_alu_src_sel, ex_alu_op, ex_jalr, ex_pc_src}), 16'd0);
    checkOutput({tag, "_mem"}, 16'({mem_wr_en, mem_rd_en, mem_funct3}), 16'd0);
    checkOutput({tag, "_wb"}, 16'({wb_reg_wr_en, wb_result_sel}), 16'd0);
    checkOutput({tag, "_illegal"}, 16'(illegal_instr), 16'd0);
  endtask

  logic [6:0] op_pool [10] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_BAD};
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    reset_n = 1'b0; instr_valid = 1'b0; op_code = '0; funct3 = '0; funct7 = '0;
    stall = 1'b0; flush = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    ex_cur = '0; mem_w = '0; wb_w = '0;
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset");
    @(negedge clk) reset_n = 1'b1;

    // ADD then SUB flowing to WB
    applyStimulus(1, OP_R, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_R, 3'd0, 7'h20, 0, 0, 0, 0, 0);
    applyIdle(3);

    // Taken BEQ squashes a following branch in ID; not-taken BNE lets the next op through
    applyStimulus(1, OP_BRANCH, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_BRANCH, 3'd1, 7'h00, 0, 0, 1, 0, 0);
    applyStimulus(1, OP_BRANCH, 3'd1, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_I, 3'd0, 7'h00, 0, 0, 1, 0, 0);
    applyIdle(2);
    foreach (br_f3[k]) begin
      applyStimulus(1, OP_BRANCH, br_f3[k], 7'h00, 0, 0, 0, 0, 0);
      applyStimulus(1, OP_I, 3'd5, 7'h20, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

    // JAL in EX redirects even while ID is stalled
    applyStimulus(1, OP_JAL, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_I, 3'd3, 7'h00, 1, 0, 0, 0, 0);
    applyIdle(2);

    // LW with a one-cycle load-use stall behind it
    applyStimulus(1, OP_LOAD, 3'd2, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_R, 3'd7, 7'h00, 1, 0, 0, 0, 0);
    applyStimulus(1, OP_R, 3'd7, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_STORE, 3'd1, 7'h00, 0, 0, 0, 0, 0);
    applyIdle(3);

    // Two illegal encodings back to back, then illegal ops masked by flush
    illegal_pulses = 0;
    applyStimulus(1, OP_BAD, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_R, 3'd0, 7'h01, 0, 0, 0, 0, 0);
    applyIdle(2);
    checkOutput("illegal_pulse_count", 16'(illegal_pulses), 16'd2);
    applyStimulus(1, OP_BAD, 3'd0, 7'h00, 0, 1, 0, 0, 0);
    applyStimulus(1, OP_BRANCH, 3'd2, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_LOAD, 3'd6, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_STORE, 3'd3, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_JALR, 3'd1, 7'h00, 0, 0, 0, 0, 0);
    applyIdle(2);

    // LUI, AUIPC, JALR
    applyStimulus(1, OP_LUI, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_AUIPC, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_JALR, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_R, 3'd4, 7'h00, 0, 0, 0, 0, 0);
    applyIdle(3);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(0, 7) != 0), op_pool[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) == 0) ? 7'h01 : (($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset with loads and stores in flight
    applyStimulus(1, OP_LOAD, 3'd4, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_STORE, 3'd2, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_LOAD, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 checkAllZero("async_reset");
    exp_q.delete();
    ex_cur = '0; mem_w = '0; wb_w = '0;
    instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    applyStimulus(1, OP_STORE, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, OP_I, 3'd1, 7'h00, 0, 0, 0, 0, 0);
    applyIdle(3);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
    $finish;
  end

endmodule
